// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed driver for NDIG hex 7-segment digits on one
// shared segment bus. A shadow copy of the display data is loaded only at frame
// boundaries, so a frame is never torn between old and new values.
// Optional feature macro: BLINK_EN (adds blink_i and a frame-based blink phase).
module seg7_scan_ctrl #(
  parameter int NDIG       = 8,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [4*NDIG-1:0]   val_i,
  input  logic [NDIG-1:0]     dp_i,
  input  logic [NDIG-1:0]     en_i,
  input  logic                lzb_i,
`ifdef BLINK_EN
  input  logic [NDIG-1:0]     blink_i,
`endif
  output logic [6:0]          seg_o,
  output logic                dp_o,
  output logic [NDIG-1:0]     an_o
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  // Inactive pin levels; XOR with these converts active-high internals to pins.
  localparam logic            DP_OFF   = (ACTIVE_LOW != 0);
  localparam logic [6:0]      SEG_OFF  = {7{DP_OFF}};
  localparam logic [NDIG-1:0] AN_OFF   = {NDIG{DP_OFF}};

  logic [DW-1:0]     div_cnt;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              frame_end;
  logic              load_fire;
  logic [4*NDIG-1:0] sh_val;
  logic [NDIG-1:0]   sh_dp;
  logic [NDIG-1:0]   sh_en;
  logic [NDIG-1:0]   sh_mask;
  logic [NDIG-1:0]   lz_mask;
  logic              lz_run;
  logic [NDIG-1:0]   an_hot;
  logic [3:0]        cur_nib;
  logic              blink_blank;
  logic              dig_blank;

  // Active-low glyph for one hex nibble (segment order g..a).
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // Per-digit down-counter; digit index advances at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= DIV_LOAD;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= DIV_LOAD;
      idx     <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      div_cnt <= div_cnt - DW'(1);
    end
  end

  assign tick       = (div_cnt == '0);
  assign frame_end  = tick && (idx == IDX_LAST);
  assign load_ready = frame_end;
  assign load_fire  = load_valid && load_ready;

  // Leading-zero mask: blank from the top digit down until a non-zero nibble; digit 0 always kept.
  always_comb begin
    lz_mask = '0;
    lz_run  = lzb_i;
    for (int k = NDIG - 1; k >= 1; k--) begin
      if (lz_run && (val_i[4*k +: 4] == 4'h0)) lz_mask[k] = 1'b1;
      else                                      lz_run     = 1'b0;
    end
  end

  // Shadow registers, updated only on an accepted load at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_val  <= '0;
      sh_dp   <= '0;
      sh_en   <= '0;
      sh_mask <= '0;
    end else if (load_fire) begin
      sh_val  <= val_i;
      sh_dp   <= dp_i;
      sh_en   <= en_i;
      sh_mask <= lz_mask;
    end
  end

`ifdef BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_DIV - 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // Frame down-counter; blink phase toggles each time it expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= BLINK_LOAD;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt == '0) begin
        blink_cnt <= BLINK_LOAD;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt - BW'(1);
      end
    end
  end

  assign blink_blank = ~blink_on & blink_i[idx];
`else
  logic [31:0] unused_blink_div;
  assign unused_blink_div = BLINK_DIV;
  assign blink_blank      = 1'b0;
`endif

  // One-hot digit select for the current index.
  always_comb begin
    an_hot = '0;
    for (int k = 0; k < NDIG; k++) an_hot[k] = (idx == IW'(k));
  end

  assign cur_nib   = sh_val[{idx, 2'b00} +: 4];
  assign dig_blank = ~sh_en[idx] | sh_mask[idx] | blink_blank;

  // Registered pin drive; anodes go dark on the tick cycle so segments change unselected.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_o <= SEG_OFF;
      dp_o  <= DP_OFF;
      an_o  <= AN_OFF;
    end else begin
      an_o  <= tick ? AN_OFF : (an_hot ^ AN_OFF);
      seg_o <= dig_blank ? SEG_OFF : (hex_glyph(cur_nib) ^ ~SEG_OFF);
      dp_o  <= (dig_blank || !sh_dp[idx]) ? DP_OFF : ~DP_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl (NDIG=4, CLK_DIV=4, ACTIVE_LOW=1, BLINK_DIV=2)
// against a frame/position reference model. Honours BLINK_EN when defined.
module tb_seg7_scan_ctrl;

  localparam int NDIG = 4;
  localparam int CDIV = 4;
  localparam int FRAME = NDIG * CDIV;
  localparam int BDIV = 2;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] val_i;
  logic [3:0]  dp_i;
  logic [3:0]  en_i;
  logic        lzb_i;
  logic [3:0]  blink_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NDIG(NDIG), .CLK_DIV(CDIV), .ACTIVE_LOW(1), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .val_i(val_i), .dp_i(dp_i), .en_i(en_i), .lzb_i(lzb_i),
`ifdef BLINK_EN
    .blink_i(blink_i),
`endif
    .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: cycle count since reset release, shadow copy, expected pins.
  int         c;
  logic [3:0] m_val [4];
  logic [3:0] m_dp, m_en, m_mask;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic       accepted;
  int         tbl_i;

  // Directed loads used first: {val, dp, en, lzb}.
  logic [15:0] t_val [4] = '{16'h1A3E, 16'h0050, 16'h0000, 16'h0000};
  logic [3:0]  t_dp  [4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000};
  logic [3:0]  t_en  [4] = '{4'hF, 4'hF, 4'hF, 4'b1110};
  logic        t_lzb [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s c=%0d got=%h exp=%h", tag, c, got, exp);
    end
  endtask

  task automatic check_cycle();
    check_val("load_ready", load_ready, (c % FRAME) == FRAME - 1);
    check_val("an_o", an_o, exp_an);
    check_val("seg_o", seg_o, exp_seg);
    check_val("dp_o", dp_o, exp_dp);
  endtask

  task automatic clear_model();
    c = 0;
    for (int k = 0; k < 4; k++) m_val[k] = 4'h0;
    m_dp = '0; m_en = '0; m_mask = '0;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    accepted = 1'b0;
  endtask

  // Hold reset three edges, checking inactive pins and no ready after each.
  task automatic apply_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_val("rst_an", an_o, 4'hF);
      check_val("rst_seg", seg_o, 7'h7F);
      check_val("rst_dp", dp_o, 1'b1);
      check_val("rst_ready", load_ready, 1'b0);
    end
    rst = 1'b0;
    clear_model();
  endtask

  // Producer: hold offered data until accepted, then offer the next item.
  task automatic drive_inputs();
    if (!load_valid || accepted) begin
      if (tbl_i < 4) begin
        val_i = t_val[tbl_i]; dp_i = t_dp[tbl_i]; en_i = t_en[tbl_i]; lzb_i = t_lzb[tbl_i];
        load_valid = 1'b1;
        tbl_i++;
      end else begin
        for (int k = 0; k < 4; k++)
          val_i[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_i  = 4'($urandom);
        en_i  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        lzb_i = 1'($urandom);
        load_valid = ($urandom_range(0, 2) != 0);
      end
    end
    blink_i = 4'($urandom);
  endtask

  // Predict next cycle's pins from this cycle's position, then apply any load.
  task automatic advance_model();
    int  idx;
    int  top;
    logic blink_off;
    logic blank;
    idx = (c / CDIV) % NDIG;
`ifdef BLINK_EN
    blink_off = (((c / FRAME) / BDIV) % 2) == 1;
`else
    blink_off = 1'b0;
`endif
    exp_an = ((c % CDIV) == CDIV - 1) ? 4'hF : ~(4'b0001 << idx);
    blank  = !m_en[idx] || m_mask[idx] || (blink_off && blink_i[idx]);
    exp_seg = blank ? 7'h7F : GLYPH[m_val[idx]];
    exp_dp  = blank || !m_dp[idx];
    accepted = load_valid && ((c % FRAME) == FRAME - 1);
    if (accepted) begin
      top = 0;
      for (int k = 0; k < 4; k++) begin
        m_val[k] = val_i[4*k +: 4];
        if (val_i[4*k +: 4] != 4'h0) top = k;
      end
      for (int k = 0; k < 4; k++) m_mask[k] = lzb_i && (k > top);
      m_dp = dp_i;
      m_en = en_i;
    end
  endtask

  initial begin
    load_valid = 1'b0; val_i = '0; dp_i = '0; en_i = '0; lzb_i = 1'b0; blink_i = '0;
    tbl_i = 0;
    clear_model();
    @(negedge clk);
    apply_reset();
    for (int n = 0; n < 1400; n++) begin
      check_cycle();
      if (n == 500) begin
        apply_reset();
        continue;
      end
      drive_inputs();
      advance_model();
      @(posedge clk);
      c++;
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
